hq2x_scanout: RTL and testbench

- Read-side consumer of the Hq2x 4-line output buffer.
- Generates 640x480@60 VGA timing from one clock and drives read_x into the upscaler.
- Takes the 1-cycle-latency outpixel back and emits aligned RGB555 plus syncs and data-enable.
- Locks its frame start to the upscaler's frame_available pulse and detects loss of lock.

---
 rtl/hq2x_video_pkg.sv | 45 ++++
 rtl/vga_timing_counter.sv | 81 ++++++++
 rtl/hq2x_scanout.sv | 172 +++++++++++++++++
 tb/tb_hq2x_scanout.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hq2x_video_pkg.sv
// Shared timing constants, lock-state enum and pixel/control types for the Hq2x scan-out path.
// Latency: n/a (types and constants only).
// Backpressure: n/a; scan-out is a free-running raster with no flow control.
package hq2x_video_pkg;

    // Raster geometry at 640x480@60.
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    // The 512-pixel upscaled image sits inside the visible line starting at IMG_LEFT.
    localparam int IMG_LEFT  = 64;
    localparam int IMG_WIDTH = 512;

    typedef enum logic {
        LOCK = 1'b0,
        RUN  = 1'b1
    } scan_state_e;

    // {b[4:0], g[4:0], r[4:0]}
    typedef logic [14:0] rgb555_t;

    // Per-pixel control bits that travel down the delay pipeline next to the pixel.
    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic de;
        logic in_img;
    } vid_ctl_t;

    localparam vid_ctl_t VID_CTL_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, de: 1'b0, in_img: 1'b0};

endpackage

// File: rtl/vga_timing_counter.sv
// Horizontal/vertical raster counters with wrap detection and combinational sync/enable decode.
// Latency: decode outputs are combinational from the registered counters (stage 0).
// Backpressure: none; counters free-run while run_i is high and sit at (0,0) otherwise.
//
// Ports:
//   clk, reset_n      pixel clock, synchronous active-low reset
//   run_i             count enable; low forces both counters to 0
//   h_cnt_o, v_cnt_o  current raster position
//   frame_end_o       high on the last pixel of the frame (h and v both about to wrap)
//   hsync_n_o, vsync_n_o, de_o  raw stage-0 decode of the position
module vga_timing_counter
    import hq2x_video_pkg::*;
#(
    parameter int H_VISIBLE = hq2x_video_pkg::H_VISIBLE,
    parameter int H_FRONT   = hq2x_video_pkg::H_FRONT,
    parameter int H_SYNC    = hq2x_video_pkg::H_SYNC,
    parameter int H_BACK    = hq2x_video_pkg::H_BACK,
    parameter int V_VISIBLE = hq2x_video_pkg::V_VISIBLE,
    parameter int V_FRONT   = hq2x_video_pkg::V_FRONT,
    parameter int V_SYNC    = hq2x_video_pkg::V_SYNC,
    parameter int V_BACK    = hq2x_video_pkg::V_BACK
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run_i,
    output logic [9:0] h_cnt_o,
    output logic [9:0] v_cnt_o,
    output logic       frame_end_o,
    output logic       hsync_n_o,
    output logic       vsync_n_o,
    output logic       de_o
);

    localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_S   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_E   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_S   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_E   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       h_end, v_end;

    assign h_end = (h_cnt_q == H_LAST);
    assign v_end = (v_cnt_q == V_LAST);

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!run_i) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_end) begin
            h_cnt_d = '0;
            v_cnt_d = v_end ? 10'd0 : v_cnt_q + 10'd1;
        end else begin
            h_cnt_d = h_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o     = h_cnt_q;
    assign v_cnt_o     = v_cnt_q;
    assign frame_end_o = h_end && v_end;
    assign hsync_n_o   = !((h_cnt_q >= HS_S) && (h_cnt_q < HS_E));
    assign vsync_n_o   = !((v_cnt_q >= VS_S) && (v_cnt_q < VS_E));
    assign de_o        = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);

endmodule

// File: rtl/hq2x_scanout.sv
// VGA scan-out for the Hq2x line buffer: raster timing, read_x addressing, frame lock to frame_available.
// Latency: 3 clk from raster position to vga_* outputs (address reg, upscaler read, output reg).
// Backpressure: none; a missing frame_available at frame end drops to LOCK and idles the outputs.
//
// Ports:
//   clk, reset_n     pixel clock, synchronous active-low reset
//   frame_available  upscaler pulse: first two output lines are ready
//   read_x           {line_in_pair, column[8:0]} read address into the upscaler output buffer
//   outpixel         upscaler pixel, valid one clk after read_x
//   vga_rgb/hsync/vsync/de  aligned video out (syncs active low)
//   locked           high while scanning out a frame
//   missed_count     saturating count of frames that ended without frame_available
module hq2x_scanout
    import hq2x_video_pkg::*;
#(
    parameter int H_VISIBLE = hq2x_video_pkg::H_VISIBLE,
    parameter int H_FRONT   = hq2x_video_pkg::H_FRONT,
    parameter int H_SYNC    = hq2x_video_pkg::H_SYNC,
    parameter int H_BACK    = hq2x_video_pkg::H_BACK,
    parameter int V_VISIBLE = hq2x_video_pkg::V_VISIBLE,
    parameter int V_FRONT   = hq2x_video_pkg::V_FRONT,
    parameter int V_SYNC    = hq2x_video_pkg::V_SYNC,
    parameter int V_BACK    = hq2x_video_pkg::V_BACK,
    parameter int IMG_LEFT  = hq2x_video_pkg::IMG_LEFT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_available,
    output logic [9:0]  read_x,
    input  logic [14:0] outpixel,
    output logic [14:0] vga_rgb,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_de,
    output logic        locked,
    output logic [7:0]  missed_count
);

    localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
    localparam logic [9:0] IMG_L = 10'(IMG_LEFT);
    localparam logic [9:0] IMG_R = 10'(IMG_LEFT + IMG_WIDTH);

    scan_state_e state_q, state_d;
    logic        fa_seen_q, fa_seen_d;
    logic [7:0]  missed_q, missed_d;
    logic        running;

    logic [9:0]  h_cnt, v_cnt;
    logic        frame_end, hsync_n_raw, vsync_n_raw, de_raw;
    logic        in_win;
    logic [8:0]  h_off;

    logic [9:0]  read_x_q, read_x_d;
    vid_ctl_t    ctl_s0, ctl_d1_q, ctl_d2_q, ctl_d3_q;
    rgb555_t     rgb_q, rgb_d;

    assign running = (state_q == RUN);

    vga_timing_counter #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk         (clk),
        .reset_n     (reset_n),
        .run_i       (running),
        .h_cnt_o     (h_cnt),
        .v_cnt_o     (v_cnt),
        .frame_end_o (frame_end),
        .hsync_n_o   (hsync_n_raw),
        .vsync_n_o   (vsync_n_raw),
        .de_o        (de_raw)
    );

    // Lock FSM. The pulse that locks does not count for the first frame; each later frame
    // must see frame_available somewhere in it, the last cycle included.
    always_comb begin
        state_d   = state_q;
        fa_seen_d = fa_seen_q;
        missed_d  = missed_q;
        case (state_q)
            LOCK: begin
                if (frame_available) begin
                    state_d   = RUN;
                    fa_seen_d = 1'b0;
                end
            end
            RUN: begin
                if (frame_available) begin
                    fa_seen_d = 1'b1;
                end
                if (frame_end) begin
                    fa_seen_d = 1'b0;
                    if (!fa_seen_q && !frame_available) begin
                        state_d = LOCK;
                        if (missed_q != 8'hFF) begin
                            missed_d = missed_q + 8'd1;
                        end
                    end
                end
            end
            default: state_d = LOCK;
        endcase
    end

    // Stage 0: window test and control decode. Outside RUN only idle values enter the
    // pipeline, so leaving RUN lets in-flight pulses finish and starts no new ones.
    assign in_win = (v_cnt < V_VIS) && (h_cnt >= IMG_L) && (h_cnt < IMG_R);
    assign h_off  = 9'(h_cnt - IMG_L);

    always_comb begin
        ctl_s0 = VID_CTL_IDLE;
        if (running) begin
            ctl_s0.hsync_n = hsync_n_raw;
            ctl_s0.vsync_n = vsync_n_raw;
            ctl_s0.de      = de_raw;
            ctl_s0.in_img  = in_win;
        end
    end

    // Address holds outside the window; the in_img flag is what blanks those pixels.
    always_comb begin
        read_x_d = read_x_q;
        if (ctl_s0.in_img) begin
            read_x_d = {v_cnt[0], h_off};
        end
    end

    // Stage 3 pixel: outpixel is the upscaler's answer to the stage-1 address.
    always_comb begin
        rgb_d = '0;
        if (ctl_d2_q.in_img) begin
            rgb_d = outpixel;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= LOCK;
            fa_seen_q <= 1'b0;
            missed_q  <= '0;
            read_x_q  <= '0;
            ctl_d1_q  <= VID_CTL_IDLE;
            ctl_d2_q  <= VID_CTL_IDLE;
            ctl_d3_q  <= VID_CTL_IDLE;
            rgb_q     <= '0;
        end else begin
            state_q   <= state_d;
            fa_seen_q <= fa_seen_d;
            missed_q  <= missed_d;
            read_x_q  <= read_x_d;
            ctl_d1_q  <= ctl_s0;
            ctl_d2_q  <= ctl_d1_q;
            ctl_d3_q  <= ctl_d2_q;
            rgb_q     <= rgb_d;
        end
    end

    assign read_x       = read_x_q;
    assign vga_rgb      = rgb_q;
    assign vga_hsync    = ctl_d3_q.hsync_n;
    assign vga_vsync    = ctl_d3_q.vsync_n;
    assign vga_de       = ctl_d3_q.de;
    assign locked       = running;
    assign missed_count = missed_q;

endmodule

// File: tb/tb_hq2x_scanout.sv
// Directed bench for hq2x_scanout. The main instance keeps the full 800-clock line but uses a
// 10-line frame (vsync still 2 lines = 1600 clk) so several frames fit; a tiny-raster second
// instance is used to drive missed_count into saturation.
module tb_hq2x_scanout;

    localparam int FRAME = 800 * 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        frame_available;
    logic [9:0]  read_x;
    logic [14:0] outpixel = '0;
    logic [14:0] vga_rgb;
    logic        vga_hsync, vga_vsync, vga_de, locked;
    logic [7:0]  missed_count;

    logic        sat_reset_n;
    logic        sat_fa;
    logic [9:0]  sat_read_x;
    logic [14:0] sat_pix = '0;
    logic [14:0] sat_rgb;
    logic        sat_hsync, sat_vsync, sat_de, sat_locked;
    logic [7:0]  sat_missed;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit fa_auto = 1'b0;
    int hs_fall_prev = 0;

    hq2x_scanout #(
        .V_VISIBLE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
    ) u_dut (
        .clk (clk), .reset_n (reset_n), .frame_available (frame_available),
        .read_x (read_x), .outpixel (outpixel), .vga_rgb (vga_rgb),
        .vga_hsync (vga_hsync), .vga_vsync (vga_vsync), .vga_de (vga_de),
        .locked (locked), .missed_count (missed_count)
    );

    hq2x_scanout #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
        .V_VISIBLE (2), .V_FRONT (1), .V_SYNC (1), .V_BACK (0), .IMG_LEFT (2)
    ) u_sat (
        .clk (clk), .reset_n (sat_reset_n), .frame_available (sat_fa),
        .read_x (sat_read_x), .outpixel (sat_pix), .vga_rgb (sat_rgb),
        .vga_hsync (sat_hsync), .vga_vsync (sat_vsync), .vga_de (sat_de),
        .locked (sat_locked), .missed_count (sat_missed)
    );

    // Upscaler stand-in: registered read, distinctive value at address 0x005.
    function automatic logic [14:0] pix_model(input logic [9:0] rx);
        if (rx == 10'h005) return 15'h7C1F;
        return {rx[4:0], rx} ^ 15'h1234;
    endfunction

    always @(posedge clk) outpixel <= pix_model(read_x);

    // One clock; pixel k (k clocks after the locking pulse's cycle) shows read_x at cyc=k+2
    // and vga_* at cyc=k+4. With fa_auto, frame_available lands on each frame's last cycle.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (fa_auto) frame_available = (cyc % FRAME == 0);
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; frame_available = 1'b0;
        sat_reset_n = 1'b0; sat_fa = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({vga_de, vga_hsync, vga_vsync} !== 3'b011) begin errors++; $display("FAIL reset_ctl: got %b expected 011", {vga_de, vga_hsync, vga_vsync}); end
        checks++; if (vga_rgb !== 15'h0) begin errors++; $display("FAIL reset_rgb: got %h expected 0000", vga_rgb); end
        checks++; if (read_x !== 10'h0) begin errors++; $display("FAIL reset_read_x: got %h expected 000", read_x); end
        checks++; if ({locked, missed_count} !== 9'h0) begin errors++; $display("FAIL reset_lock: got locked=%b missed=%0d expected 0/0", locked, missed_count); end
        reset_n = 1'b1; sat_reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if ({locked, vga_de, vga_hsync, vga_vsync} !== 4'b0011) begin errors++; $display("FAIL idle_lock: got %b expected 0011", {locked, vga_de, vga_hsync, vga_vsync}); end
    endtask

    task automatic test_lock();
        cyc = 0; frame_available = 1'b1; fa_auto = 1'b1;
        step();
        checks++; if ({locked, vga_de} !== 2'b10) begin errors++; $display("FAIL lock_next: got locked,de=%b expected 10", {locked, vga_de}); end
        step_to(3);
        checks++; if (vga_de !== 1'b0) begin errors++; $display("FAIL de_early: got %b expected 0", vga_de); end
        step_to(4);
        checks++; if ({vga_de, vga_hsync, vga_rgb} !== {2'b11, 15'h0}) begin errors++; $display("FAIL de_rise: got de=%b hs=%b rgb=%h expected 1 1 0000", vga_de, vga_hsync, vga_rgb); end
    endtask

    task automatic test_pixel_return();
        step_to(67);
        checks++; if (vga_rgb !== 15'h0) begin errors++; $display("FAIL col63_rgb: got %h expected 0000", vga_rgb); end
        step_to(68);
        checks++; if (vga_rgb !== pix_model(10'h000)) begin errors++; $display("FAIL col64_rgb: got %h expected %h", vga_rgb, pix_model(10'h000)); end
        step_to(71);
        checks++; if (read_x !== 10'h005) begin errors++; $display("FAIL col69_read_x: got %h expected 005", read_x); end
        step_to(73);
        checks++; if ({vga_de, vga_rgb} !== {1'b1, 15'h7C1F}) begin errors++; $display("FAIL col69_rgb: got de=%b rgb=%h expected 1 7c1f", vga_de, vga_rgb); end
        step_to(579);
        checks++; if (vga_rgb !== pix_model(10'h1FF)) begin errors++; $display("FAIL col575_rgb: got %h expected %h", vga_rgb, pix_model(10'h1FF)); end
        step_to(580);
        checks++; if ({vga_de, vga_rgb} !== {1'b1, 15'h0}) begin errors++; $display("FAIL col576_rgb: got de=%b rgb=%h expected 1 0000", vga_de, vga_rgb); end
    endtask

    task automatic test_hsync();
        int de_fall = -1, hs_fall = -1, hs_rise = -1;
        while (cyc < 800) begin
            step();
            if (de_fall < 0 && !vga_de) de_fall = cyc;
            if (hs_fall < 0 && !vga_hsync) hs_fall = cyc;
            if (hs_fall >= 0 && hs_rise < 0 && vga_hsync) hs_rise = cyc;
        end
        checks++; if (de_fall !== 644) begin errors++; $display("FAIL de_fall: got cyc %0d expected 644", de_fall); end
        checks++; if (hs_fall !== 660) begin errors++; $display("FAIL hs_fall: got cyc %0d expected 660", hs_fall); end
        checks++; if (hs_rise - hs_fall !== 96) begin errors++; $display("FAIL hs_width: got %0d expected 96", hs_rise - hs_fall); end
        hs_fall_prev = hs_fall;
    endtask

    task automatic test_read_x();
        step_to(865);
        checks++; if (read_x !== 10'h1FF) begin errors++; $display("FAIL read_x_hold_left: got %h expected 1ff", read_x); end
        step_to(866);
        checks++; if (read_x !== 10'h200) begin errors++; $display("FAIL read_x_v1_h64: got %h expected 200", read_x); end
        step_to(1377);
        checks++; if (read_x !== 10'h3FF) begin errors++; $display("FAIL read_x_v1_h575: got %h expected 3ff", read_x); end
        step_to(1378);
        checks++; if (read_x !== 10'h3FF) begin errors++; $display("FAIL read_x_v1_h576: got %h expected 3ff", read_x); end
        step_to(1379);
        checks++; if (vga_rgb !== pix_model(10'h3FF)) begin errors++; $display("FAIL rgb_v1_h575: got %h expected %h", vga_rgb, pix_model(10'h3FF)); end
        step_to(1380);
        checks++; if ({vga_de, vga_rgb} !== {1'b1, 15'h0}) begin errors++; $display("FAIL rgb_v1_h576: got de=%b rgb=%h expected 1 0000", vga_de, vga_rgb); end
    endtask

    task automatic test_frames();
        int vs_low[4] = '{0, 0, 0, 0};
        int falls = 0, bad = 0, drops = 0, idx;
        logic hs_prev;
        hs_prev = vga_hsync;
        while (cyc < 4 * FRAME + 4) begin
            step();
            if (!locked) drops++;
            idx = (cyc - 4) / FRAME;
            if (!vga_vsync && idx < 4) vs_low[idx]++;
            if (hs_prev && !vga_hsync) begin
                falls++;
                if (cyc - hs_fall_prev != 800) bad++;
                hs_fall_prev = cyc;
            end
            hs_prev = vga_hsync;
        end
        checks++; if (drops !== 0) begin errors++; $display("FAIL lock_held: got %0d unlocked cycles expected 0", drops); end
        for (int f = 0; f < 4; f++) begin
            checks++; if (vs_low[f] !== 1600) begin errors++; $display("FAIL vsync_width_f%0d: got %0d expected 1600", f, vs_low[f]); end
        end
        checks++; if (falls !== 39) begin errors++; $display("FAIL hs_count: got %0d expected 39", falls); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL hs_period: got %0d bad periods expected 0", bad); end
        checks++; if (missed_count !== 8'd0) begin errors++; $display("FAIL missed_zero: got %0d expected 0", missed_count); end
    endtask

    task automatic test_miss();
        fa_auto = 1'b0;
        step_to(5 * FRAME);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL miss_last_cycle: got locked=%b expected 1", locked); end
        step();
        checks++; if ({locked, missed_count} !== {1'b0, 8'd1}) begin errors++; $display("FAIL miss_drop: got locked=%b missed=%0d expected 0 1", locked, missed_count); end
        step_to(5 * FRAME + 10);
        checks++; if ({vga_de, vga_hsync, vga_vsync, vga_rgb} !== {3'b011, 15'h0}) begin errors++; $display("FAIL miss_idle: got %b_%h expected 011_0000", {vga_de, vga_hsync, vga_vsync}, vga_rgb); end
        checks++; if (read_x !== 10'h3FF) begin errors++; $display("FAIL miss_read_x_hold: got %h expected 3ff", read_x); end
        cyc = 0; frame_available = 1'b1; fa_auto = 1'b1;
        step();
        checks++; if ({locked, missed_count} !== {1'b1, 8'd1}) begin errors++; $display("FAIL relock: got locked=%b missed=%0d expected 1 1", locked, missed_count); end
        step_to(4);
        checks++; if (vga_de !== 1'b1) begin errors++; $display("FAIL relock_de: got %b expected 1", vga_de); end
    endtask

    task automatic test_reset_mid();
        step_to(2701);
        checks++; if ({vga_de, read_x} !== {1'b1, 10'h2EB}) begin errors++; $display("FAIL pre_reset: got de=%b read_x=%h expected 1 2eb", vga_de, read_x); end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++; if ({vga_de, vga_hsync, vga_vsync, vga_rgb} !== {3'b011, 15'h0}) begin errors++; $display("FAIL mid_reset_out: got %b_%h expected 011_0000", {vga_de, vga_hsync, vga_vsync}, vga_rgb); end
        checks++; if ({locked, missed_count, read_x} !== 19'h0) begin errors++; $display("FAIL mid_reset_state: got locked=%b missed=%0d read_x=%h expected 0 0 000", locked, missed_count, read_x); end
        fa_auto = 1'b0;
        step_to(2708);
        checks++; if ({locked, vga_de} !== 2'b00) begin errors++; $display("FAIL post_reset_idle: got %b expected 00", {locked, vga_de}); end
        reset_n = 1'b0; frame_available = 1'b1;
        step();
        reset_n = 1'b1; frame_available = 1'b0;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_vs_fa: got locked=%b expected 0", locked); end
        step();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_vs_fa_after: got locked=%b expected 0", locked); end
    endtask

    task automatic test_saturate();
        int n;
        bit timeout = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            sat_fa = 1'b1;
            @(negedge clk);
            sat_fa = 1'b0;
            n = 0;
            while (sat_locked && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) begin
                timeout = 1'b1;
                break;
            end
            if (i == 1) begin
                checks++; if (sat_missed !== 8'd1) begin errors++; $display("FAIL sat_first: got %0d expected 1", sat_missed); end
            end
            if (i == 255) begin
                checks++; if (sat_missed !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected 255", sat_missed); end
            end
        end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL sat_timeout: got locked stuck high expected drop within 100 clk"); end
        checks++; if (sat_missed !== 8'd255) begin errors++; $display("FAIL sat_300: got %0d expected 255", sat_missed); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_pixel_return();
        test_hsync();
        test_read_x();
        test_frames();
        test_miss();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
